// File: rtl/error_diag_pkg.sv
// Shared constants and types for the error-counter diagnostics path.
// Counter layout on cnt_bus, stream geometry and the snapshot sequencer states.
package error_diag_pkg;

  localparam int NUM_CNT = 9;
  localparam int CNT_W   = 32;

  localparam logic [7:0] HDR_MAGIC = 8'hE5;

  localparam int IDX_CRC_DATA   = 0;
  localparam int IDX_CRC_ADDR   = 1;
  localparam int IDX_MISSING_AM = 2;
  localparam int IDX_MISSING_DAM = 3;
  localparam int IDX_OVERRUN    = 4;
  localparam int IDX_UNDERRUN   = 5;
  localparam int IDX_SEEK       = 6;
  localparam int IDX_WRITE_FAULT = 7;
  localparam int IDX_PLL_UNLOCK = 8;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } snap_state_e;

endpackage

// File: rtl/error_snap_timer.sv
// Free-running interval timer producing a one-cycle fire pulse every auto_period clocks.
// A period of zero parks the counter at 0 and suppresses firing.
module error_snap_timer
  import error_diag_pkg::*;
#(
  parameter int TIMER_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TIMER_W-1:0] auto_period,
  output logic               fire
);

  logic [TIMER_W-1:0] count;

  // >= rather than == so shrinking the period below the current count fires promptly
  always_comb begin
    fire = (auto_period != '0) && (count >= (auto_period - TIMER_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset || (auto_period == '0) || fire) begin
      count <= '0;
    end else begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/error_snapshot_ctrl.sv
// Captures the error counter bank atomically on host or timer request and streams it
// as a header word plus one word per counter; optionally clears the bank at capture.
module error_snapshot_ctrl
  import error_diag_pkg::*;
#(
  parameter int TIMER_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CNT*CNT_W-1:0] cnt_bus,
  input  logic                     snap_req,
  input  logic                     clear_en,
  input  logic [TIMER_W-1:0]       auto_period,
  output logic                     clear_all,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic [15:0]              seq,
  output logic [7:0]               snap_dropped
);

  localparam int IDX_W = $clog2(NUM_CNT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT);

  snap_state_e              state, state_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [NUM_CNT*CNT_W-1:0] shadow;
  logic                     src;
  logic                     auto_pend;
  logic                     fire;
  logic                     auto_on;
  logic                     host_trig;
  logic                     auto_trig;
  logic                     accept;
  logic [CNT_W-1:0]         header;

  error_snap_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .auto_period (auto_period),
    .fire        (fire)
  );

  assign auto_on = (auto_period != '0);
  assign header  = {HDR_MAGIC, src, 7'd0, seq};

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    host_trig = 1'b0;
    auto_trig = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      ST_IDLE: begin
        host_trig = snap_req;
        auto_trig = auto_on && (fire || auto_pend);
        if (host_trig || auto_trig) begin
          state_nxt = ST_STREAM;
          idx_nxt   = '0;
        end
      end
      ST_STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (idx == LAST_IDX);
        if (idx == '0) begin
          out_data = header;
        end else begin
          out_data = shadow[(int'(idx) - 1) * CNT_W +: CNT_W];
        end
        accept = out_ready;
        if (accept) begin
          if (out_last) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      shadow       <= '0;
      src          <= 1'b0;
      auto_pend    <= 1'b0;
      clear_all    <= 1'b0;
      seq          <= '0;
      snap_dropped <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      clear_all <= (host_trig || auto_trig) && clear_en;
      if (host_trig || auto_trig) begin
        shadow <= cnt_bus;
        src    <= !host_trig;
      end
      // IDLE always consumes or merges any pending auto request
      if (!auto_on || (state == ST_IDLE)) begin
        auto_pend <= 1'b0;
      end else if (fire) begin
        auto_pend <= 1'b1;
      end
      if (accept && out_last) begin
        seq <= seq + 16'd1;
      end
      if ((state == ST_STREAM) && snap_req && (snap_dropped != 8'hFF)) begin
        snap_dropped <= snap_dropped + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_error_snapshot_ctrl.sv
// Self-checking bench for error_snapshot_ctrl: a queue-based snapshot model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_error_snapshot_ctrl;

  localparam int N  = 9;
  localparam int W  = 32;
  localparam int TW = 24;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*W-1:0]    cnt_bus;
  logic              snap_req;
  logic              clear_en;
  logic [TW-1:0]     auto_period;
  logic              clear_all;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic [15:0]       seq;
  logic [7:0]        snap_dropped;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  error_snapshot_ctrl #(.TIMER_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_bus      (cnt_bus),
    .snap_req     (snap_req),
    .clear_en     (clear_en),
    .auto_period  (auto_period),
    .clear_all    (clear_all),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .seq          (seq),
    .snap_dropped (snap_dropped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending snapshot is the list of words still to be delivered.
  logic [31:0] mq[$];
  int          tcount = 0;
  bit          m_pend = 0;
  logic [15:0] m_seq = '0;
  logic [7:0]  m_drop = '0;
  bit          m_clear = 0;

  always @(posedge clk) begin : model
    bit fire_m;
    if (reset) begin
      mq.delete();
      tcount  = 0;
      m_pend  = 0;
      m_seq   = '0;
      m_drop  = '0;
      m_clear = 0;
    end else begin
      fire_m  = (auto_period != 0) && (tcount >= int'(auto_period) - 1);
      tcount  = (auto_period == 0 || fire_m) ? 0 : tcount + 1;
      m_clear = 0;
      if (mq.size() == 0) begin
        if (snap_req || fire_m || (m_pend && auto_period != 0)) begin
          mq.push_back({8'hE5, !snap_req, 7'd0, m_seq});
          for (int i = 0; i < N; i++) mq.push_back(cnt_bus[i*W +: W]);
          m_clear = clear_en;
          m_pend  = 0;
        end
      end else begin
        if (snap_req && m_drop != 8'hFF) m_drop++;
        if (fire_m) m_pend = 1;
        if (out_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) m_seq++;
        end
      end
      if (auto_period == 0) m_pend = 0;
    end
  end

  // Per-cycle comparison and stream bookkeeping
  bit          chk_on = 0;
  int          cyc = 0;
  bit          sop = 1;
  int          clear_cnt = 0;
  int          hdr_cnt = 0;
  logic [31:0] hdr_last = '0;
  int          hdr_times[$];
  logic [31:0] cap[$];
  bit          capl[$];

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (chk_on) begin
      check("valid", out_valid, mq.size() != 0);
      check("busy", busy, mq.size() != 0);
      check("last", out_last, mq.size() == 1);
      if (mq.size() != 0) check("data", out_data, mq[0]);
      check("clear_all", clear_all, m_clear);
      check("seq", seq, m_seq);
      check("dropped", snap_dropped, m_drop);
      if (clear_all) clear_cnt++;
      if (reset) begin
        sop = 1;
      end else if (out_valid && out_ready) begin
        if (sop) begin
          hdr_cnt++;
          hdr_last = out_data;
          hdr_times.push_back(cyc);
        end
        cap.push_back(out_data);
        capl.push_back(out_last);
        sop = out_last;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    snap_req = 1'b1;
    tick(1);
    snap_req = 1'b0;
  endtask

  initial begin
    int h0;
    reset       = 1'b1;
    snap_req    = 1'b0;
    clear_en    = 1'b0;
    out_ready   = 1'b1;
    cnt_bus     = '0;
    auto_period = '0;
    tick(2);
    chk_on = 1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_seq", seq, 0);
    check("rst_drop", snap_dropped, 0);
    check("rst_clear", clear_all, 0);
    reset = 1'b0;
    tick(2);

    // Host snapshot, no clear
    for (int i = 0; i < N; i++) cnt_bus[i*W +: W] = 32'(i + 1);
    cap.delete(); capl.delete(); clear_cnt = 0;
    pulse_req();
    tick(14);
    check("t1_len", cap.size(), 10);
    check("t1_hdr", cap[0], 32'hE500_0000);
    for (int i = 1; i <= N; i++) check("t1_word", cap[i], 32'(i));
    check("t1_last9", capl[9], 1);
    check("t1_last8", capl[8], 0);
    check("t1_seq", seq, 1);
    check("t1_noclear", clear_cnt, 0);

    // Backpressure with clear; bus changes after capture must not leak in
    for (int i = 0; i < N; i++) cnt_bus[i*W +: W] = 32'(100 + i);
    cap.delete(); capl.delete(); clear_cnt = 0;
    clear_en = 1'b1;
    pulse_req();
    clear_en = 1'b0;
    for (int i = 0; i < N; i++) cnt_bus[i*W +: W] = $urandom;
    for (int k = 0; k < 30; k++) begin
      out_ready = k[0];
      tick(1);
    end
    out_ready = 1'b1;
    tick(5);
    check("t2_len", cap.size(), 10);
    check("t2_hdr", cap[0], 32'hE500_0001);
    for (int i = 1; i <= N; i++) check("t2_word", cap[i], 32'(99 + i));
    check("t2_clears", clear_cnt, 1);

    // Dropped host requests and saturation
    out_ready = 1'b0;
    pulse_req();
    tick(2);
    for (int k = 0; k < 3; k++) begin pulse_req(); tick(1); end
    check("t3_drop3", snap_dropped, 3);
    for (int k = 0; k < 251; k++) begin pulse_req(); tick(1); end
    check("t3_drop254", snap_dropped, 254);
    for (int k = 0; k < 2; k++) begin pulse_req(); tick(1); end
    check("t3_drop255", snap_dropped, 255);
    out_ready = 1'b1;
    tick(15);
    check("t3_seq", seq, 3);

    // Auto timer at period 100
    hdr_times.delete();
    auto_period = 24'd100;
    tick(320);
    check("t4_count", hdr_times.size(), 3);
    check("t4_gap1", hdr_times[1] - hdr_times[0], 100);
    check("t4_gap2", hdr_times[2] - hdr_times[1], 100);
    check("t4_src", hdr_last[23], 1);

    // Stall across two fires: one pending snapshot, second fire discarded
    auto_period = '0;
    tick(20);
    auto_period = 24'd70;
    h0 = hdr_cnt;
    for (int k = 0; k < 100 && hdr_cnt == h0; k++) tick(1);
    check("t4_fire_seen", hdr_cnt != h0, 1);
    out_ready = 1'b0;
    tick(150);
    out_ready = 1'b1;
    h0 = hdr_cnt;
    tick(40);
    check("t4_pending_one", hdr_cnt - h0, 1);
    check("t4_pending_src", hdr_last[23], 1);
    auto_period = '0;
    tick(40);

    // Host request coincides with the timer fire
    auto_period = 24'd20;
    tick(19);
    pulse_req();
    h0 = hdr_cnt;
    tick(14);
    auto_period = '0;
    check("t5_one", hdr_cnt - h0, 1);
    check("t5_src", hdr_last[23], 0);
    tick(30);
    check("t5_no_follow", hdr_cnt - h0, 1);

    // Reset in the middle of a stream
    out_ready = 1'b1;
    pulse_req();
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_valid", out_valid, 0);
    check("t6_seq", seq, 0);
    pulse_req();
    tick(4);
    check("t6_hdr", hdr_last, 32'hE500_0000);
    tick(12);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      snap_req  = ($urandom % 16) == 0;
      out_ready = ($urandom % 4) != 0;
      clear_en  = $urandom % 2;
      for (int i = 0; i < N; i++) cnt_bus[i*W +: W] = $urandom;
      if (($urandom % 200) == 0) begin
        case ($urandom % 5)
          0: auto_period = 24'd0;
          1: auto_period = 24'd1;
          2: auto_period = 24'd4;
          3: auto_period = 24'd13;
          default: auto_period = 24'd37;
        endcase
      end
      reset = ($urandom % 700) == 0;
      tick(1);
    end
    reset    = 1'b0;
    snap_req = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/error_snapshot_ctrl.md
# error_snapshot_ctrl

Sequencer that takes atomic snapshots of the lifetime error counter bank and streams them to the host diagnostics path. A snapshot starts from a host request or a programmable interval timer. Each snapshot optionally issues a clear to the counter bank. The block sits between the counter bank's outputs and `clear_all` input on one side, and the 32-bit diagnostics stream on the other.

## Interface
- `NUM_CNT`, 9, number of 32-bit counters on `cnt_bus`.
- `CNT_W`, 32, counter width and stream word width.
- `TIMER_W`, 24, auto-snapshot interval counter width.

- `clk` in 1 system clock.
- `reset` in 1 reset, synchronous, active-high.
- `cnt_bus` in NUM_CNT*CNT_W. Counters packed with index 0 in the LSBs. Order: crc_data, crc_addr, missing_am, missing_dam, overrun, underrun, seek, write_fault, pll_unlock.
- `snap_req` in 1 host snapshot request, single-cycle pulse.
- `clear_en` in 1 when 1, each snapshot clears the counter bank.
- `auto_period` in TIMER_W, auto-snapshot interval in clocks; 0 disables.
- `clear_all` out 1 clear pulse to the counter bank.
- `out_valid` out 1 stream word valid.
- `out_ready` in 1 stream consumer ready.
- `out_data` out CNT_W stream word.
- `out_last` out 1 marks the final word of a snapshot.
- `busy` out 1 a snapshot is being streamed.
- `seq` out 16 count of completed snapshots, wraps.
- `snap_dropped` out 8 host requests rejected while busy, saturating.

## Operation
- States: IDLE and STREAM.
- Trigger sources, evaluated in IDLE:
  - `snap_req`, the host source.
  - auto fire from the interval timer.
  - an auto request left pending from an earlier fire.
- Host and auto triggers in the same cycle merge into one snapshot with source = host. This also clears any pending auto request.
- On a trigger in IDLE:
  - `shadow` is loaded from `cnt_bus` at that clock edge.
  - The source bit is latched.
  - State moves to STREAM with word index 0.
  - If `clear_en` is set, `clear_all` is registered high for exactly one cycle.
- Stream format, NUM_CNT+1 words:
  - Word 0 is the header: {8'hE5, src (1 = auto), 7'd0, seq[15:0]}.
  - Words 1..NUM_CNT are `shadow[i-1]` in bus order.
- The word index advances only when `out_valid && out_ready`.
- `out_valid` stays high and `out_data` stays stable until accepted. The stream has no bubbles while `out_ready` is held high.
- `out_last` = 1 exactly on word NUM_CNT.
- On acceptance of the last word: `seq` increments (wraps at 16'hFFFF→0) and state returns to IDLE.
- `snap_req` while in STREAM is dropped and `snap_dropped` increments, saturating at 8'hFF.
- Auto fire while in STREAM sets `auto_pend`, one entry deep. A second fire while already pending is discarded silently.
- Interval timer:
  - Counts every cycle.
  - When the count is ≥ `auto_period` − 1, it fires for one cycle and reloads 0.
  - Using ≥ means that lowering `auto_period` below the current count fires on the next cycle.
  - When `auto_period` = 0, the timer is held at 0, never fires, and `auto_pend` is cleared.
- Clear loss window: the counter bank resets at the end of the cycle where `clear_all` = 1. Error strobes occurring in the trigger cycle or the `clear_all` cycle are absent from both the snapshot and the new counts. This two-cycle loss is accepted behaviour.
- `clear_en` is sampled only at trigger.

## Timing
- Reset values: `clear_all` 0, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `seq` 0, `snap_dropped` 0. Internally `shadow` 0, timer 0, `auto_pend` 0, state IDLE.
- Trigger in cycle T:
  - `busy`, `out_valid` and the header on `out_data` appear in cycle T+1.
  - `clear_all` is high in T+1 only.
- With `out_ready` held at 1, words appear in T+1..T+NUM_CNT+1.
- After the last accepted word, `busy` is 0 in the following cycle.
- A pending auto request starts a snapshot no earlier than that first IDLE cycle. Its header appears one cycle later.
- At least one IDLE cycle always separates snapshots.
- Reset mid-stream: the stream aborts immediately. Next cycle `out_valid` = 0 and the partial snapshot is discarded. `seq` is not incremented because reset zeroes it.

## Structure
- Shared package `error_diag_pkg` holds:
  - `NUM_CNT`, `CNT_W`
  - header magic 8'hE5
  - counter index localparams (`IDX_CRC_DATA`..`IDX_PLL_UNLOCK`)
  - the state enum
- One sub-module, `error_snap_timer`, implements the interval counter and fire pulse. It has inputs `clk`, `reset`, `auto_period` and output `fire`.

## Test plan
- Host snapshot, no clear: set `cnt_bus` words = 1..9, pulse `snap_req`, hold `out_ready`=1. Expect 10 words: 32'hE5000000, then 1..9. `out_last` on the 10th word, `seq`=1, `clear_all` never high.
- Backpressure with clear: `clear_en`=1, toggle `out_ready` every other cycle. Expect each word held stable until accepted, `clear_all` high exactly in T+1, and the stream content matching the pre-clear values.
- Busy drop: pulse `snap_req` three times during a stream. Expect `snap_dropped`=3 and a single snapshot. Preload 254 drops, then 2 more: expect saturation at 255.
- Auto timer: `auto_period`=100. Expect header src=1 every 100 cycles while idle. Stall `out_ready` for 150 cycles: expect one pending snapshot starting in the first IDLE cycle after completion, with the extra fire discarded.
- Simultaneous triggers: `snap_req` in the same cycle as a timer fire. Expect one snapshot with src=0 and no follow-up auto snapshot.
- Reset at word 5: expect `out_valid`=0 next cycle, `seq`=0, and a fresh request producing the header with seq 0.
